// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: runs multiplexed address/data bursts on the RTC parallel bus
// on behalf of the main control FSM. A one-cycle start strobe plus a 3-bit
// command selects the burst; write bytes are fetched through the idx
// handshake and read bytes are returned with a one-cycle rd_we strobe.
// Optional feature: define RTC_CMD_QUEUE_EN to add a one-deep pending
// command register that accepts a start arriving while a burst is running.
module rtc_bus_ctrl #(
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_GAP   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cmd,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [3:0] idx,
  output logic [7:0] rdata,
  output logic       rd_we,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PULSE_LOAD = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {IDLE, A_LOW, A_GAP, D_LOW, D_GAP, FIN} state_t;

  // Everything the burst engine needs to know about a command.
  typedef struct packed {
    logic       write;
    logic [7:0] base;
    logic [3:0] last;   // index of the final byte, N-1
  } cmd_info_t;

  function automatic cmd_info_t decode(input logic [2:0] code);
    cmd_info_t info;
    info = '0;
    case (code)
      3'd1:    info = '{write: 1'b1, base: 8'h00, last: 4'd1};  // INIT
      3'd2:    info = '{write: 1'b0, base: 8'h21, last: 4'd8};  // READ
      3'd3:    info = '{write: 1'b1, base: 8'h21, last: 4'd2};  // WR_HORA
      3'd4:    info = '{write: 1'b1, base: 8'h24, last: 4'd2};  // WR_FECHA
      3'd5:    info = '{write: 1'b1, base: 8'h41, last: 4'd2};  // WR_CRONO
      default: info = '0;
    endcase
    return info;
  endfunction

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [3:0] idx_d;
  cmd_info_t  cur, cur_d, req;
  logic       launch, launch_d;
  logic       legal, take, read_sample;

  logic [7:0] ad_out_d;
  logic       ad_oe_d, cs_n_d, rd_n_d, wr_n_d, ad_n_d, busy_d, done_d;

`ifdef RTC_CMD_QUEUE_EN
  logic       pend_valid, pend_valid_d;
  cmd_info_t  pend, pend_d;
`endif

  assign req   = decode(cmd);
  assign legal = (cmd >= 3'd1) && (cmd <= 3'd5);
  assign take  = start && legal;

  // Last cycle of a read data phase: capture the bus into rdata.
  assign read_sample = (state == D_LOW) && (cnt == 8'd0) && !cur.write;

  // State register: FSM state, phase counter, byte index, latched command.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      idx    <= 4'd0;
      cur    <= '0;
      launch <= 1'b0;
`ifdef RTC_CMD_QUEUE_EN
      pend_valid <= 1'b0;
      pend       <= '0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      cur    <= cur_d;
      launch <= launch_d;
`ifdef RTC_CMD_QUEUE_EN
      pend_valid <= pend_valid_d;
      pend       <= pend_d;
`endif
    end
  end

  // Next-state logic: phase sequencing, byte stepping and command acceptance.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    cur_d    = cur;
    launch_d = 1'b0;
`ifdef RTC_CMD_QUEUE_EN
    pend_valid_d = pend_valid;
    pend_d       = pend;
`endif
    case (state)
      IDLE: begin
        // The accepting cycle only latches the command; the bus burst starts
        // on the following edge so the strobes appear one edge after start.
        if (launch) begin
          state_d = A_LOW;
          cnt_d   = PULSE_LOAD;
        end else if (take) begin
          launch_d = 1'b1;
          cur_d    = req;
          idx_d    = 4'd0;
        end
      end
      A_LOW: begin
        if (cnt == 8'd0) begin
          state_d = A_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      A_GAP: begin
        if (cnt == 8'd0) begin
          state_d = D_LOW;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      D_LOW: begin
        if (cnt == 8'd0) begin
          state_d = D_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      D_GAP: begin
        if (cnt == 8'd0) begin
          if (idx == cur.last) begin
            state_d = FIN;
            idx_d   = 4'd0;
          end else begin
            state_d = A_LOW;
            cnt_d   = PULSE_LOAD;
            idx_d   = idx + 4'd1;
          end
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
`ifdef RTC_CMD_QUEUE_EN
        // A queued command, or one arriving right now, chains without idling.
        if (pend_valid) begin
          state_d      = A_LOW;
          cnt_d        = PULSE_LOAD;
          cur_d        = pend;
          pend_valid_d = 1'b0;
        end else if (take) begin
          state_d = A_LOW;
          cnt_d   = PULSE_LOAD;
          cur_d   = req;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef RTC_CMD_QUEUE_EN
    // Hold the first legal start seen mid-burst; later ones are dropped.
    if (take && !pend_valid && (launch || (state != IDLE && state != FIN))) begin
      pend_valid_d = 1'b1;
      pend_d       = req;
    end
`endif
  end

  // Output decode from the next state so the registered pins line up with it.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    busy_d   = launch_d || (state_d inside {A_LOW, A_GAP, D_LOW, D_GAP});
    done_d   = (state_d == FIN);
    case (state_d)
      A_LOW: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = cur_d.base + {4'd0, idx_d};
      end
      D_LOW: begin
        cs_n_d = 1'b0;
        if (cur_d.write) begin
          wr_n_d  = 1'b0;
          ad_oe_d = 1'b1;
          // Capture wdata once on phase entry and hold it for the whole pulse.
          ad_out_d = (state == D_LOW) ? ad_out : wdata;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers, plus the read-byte capture and its write strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_n   <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_we  <= 1'b0;
      rdata  <= 8'h00;
    end else begin
      cs_n   <= cs_n_d;
      rd_n   <= rd_n_d;
      wr_n   <= wr_n_d;
      ad_n   <= ad_n_d;
      ad_oe  <= ad_oe_d;
      ad_out <= ad_out_d;
      busy   <= busy_d;
      done   <= done_d;
      rd_we  <= read_sample;
      if (read_sample) rdata <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: table-driven command checks, directed corner sequences and
// a randomized run, all compared cycle by cycle against a timeline model that
// derives every expected pin value from the command table and phase timing.
module tb_rtc_bus_ctrl;

  localparam int TP = 4;
  localparam int TG = 2;
  localparam int BYTE_CYC = 2 * (TP + TG);

  logic       clock, reset, start;
  logic [2:0] cmd;
  logic [7:0] wdata, ad_in, ad_out, rdata;
  logic       ad_oe, cs_n, rd_n, wr_n, ad_n, rd_we, busy, done;
  logic [3:0] idx;

  rtc_bus_ctrl #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .clock(clock), .reset(reset), .start(start), .cmd(cmd),
    .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .idx(idx), .rdata(rdata), .rd_we(rd_we), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data-selection mux and RTC readback, both keyed by the DUT's byte index.
  logic [7:0] wtab [16];
  always_comb wdata = wtab[idx];
  always_comb ad_in = 8'h50 + {4'h0, idx};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pin bundle: {cs_n,rd_n,wr_n,ad_n,ad_oe,busy,done,rd_we,ad_out,rdata,idx}
  function automatic logic [27:0] actual_vec();
    return {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, done, rd_we, ad_out, rdata, idx};
  endfunction

  // ---------------- reference model: command table + burst timeline -------
  function automatic int n_of(input logic [2:0] c);
    case (c)
      3'd1: return 2;
      3'd2: return 9;
      3'd3, 3'd4, 3'd5: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] base_of(input logic [2:0] c);
    case (c)
      3'd2, 3'd3: return 8'h21;
      3'd4: return 8'h24;
      3'd5: return 8'h41;
      default: return 8'h00;
    endcase
  endfunction

  bit         m_v = 1'b0;   // a job owns the bus timeline
  logic [2:0] m_cmd;
  int         m_org;        // cycle index that counts as k=0 for the job
  bit         p_v = 1'b0;
  logic [2:0] p_cmd;
  logic [7:0] exp_rdata = 8'h00;

  // Decide what the start sampled at edge `cyc` does to the job timeline.
  task automatic model_edge(input bit st, input logic [2:0] c);
    bit legal;
    int last, kprev;
    legal = st && (n_of(c) != 0);
    last  = 0;
    kprev = 0;
    if (m_v) begin
      last  = n_of(m_cmd) * BYTE_CYC + 1;
      kprev = cyc - 1 - m_org;
    end
    if (!m_v || kprev > last) begin
      m_v = 1'b0;
      if (legal) begin m_v = 1'b1; m_cmd = c; m_org = cyc; end
    end else if (kprev == last) begin
      m_v = 1'b0;
`ifdef RTC_CMD_QUEUE_EN
      if (p_v) begin m_v = 1'b1; m_cmd = p_cmd; m_org = cyc - 1; p_v = 1'b0; end
      else if (legal) begin m_v = 1'b1; m_cmd = c; m_org = cyc - 1; end
`endif
    end else begin
`ifdef RTC_CMD_QUEUE_EN
      if (legal && !p_v) begin p_v = 1'b1; p_cmd = c; end
`endif
    end
  endtask

  task automatic model_expect(output logic [27:0] v);
    logic cs, rd, wr, an, oe, bz, dn, we;
    logic [7:0] ao;
    logic [3:0] ix;
    int k, n, b, ph;
    cs = 1; rd = 1; wr = 1; an = 1; oe = 0; bz = 0; dn = 0; we = 0;
    ao = 8'h00; ix = 4'h0;
    if (m_v) begin
      n = n_of(m_cmd);
      k = cyc - m_org;
      if (k == 0) bz = 1'b1;
      else if (k <= n * BYTE_CYC) begin
        bz = 1'b1;
        b  = (k - 1) / BYTE_CYC;
        ph = (k - 1) % BYTE_CYC;
        ix = 4'(b);
        if (ph < TP) begin
          cs = 0; wr = 0; an = 0; oe = 1; ao = base_of(m_cmd) + 8'(b);
        end else if (ph >= TP + TG && ph < 2 * TP + TG) begin
          cs = 0;
          if (m_cmd != 3'd2) begin wr = 0; oe = 1; ao = wtab[b]; end
          else rd = 0;
        end else if (ph == 2 * TP + TG && m_cmd == 3'd2) begin
          we = 1; exp_rdata = 8'h50 + 8'(b);
        end
      end else if (k == n * BYTE_CYC + 1) dn = 1'b1;
    end
    v = {cs, rd, wr, an, oe, bz, dn, we, ao, exp_rdata, ix};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit st, input logic [2:0] c);
    logic [27:0] exp_v;
    start = st;
    cmd   = c;
    @(posedge clock);
    cyc++;
    model_edge(st, c);
    #1;
    start = 1'b0;
    cmd   = 3'($urandom_range(0, 7));
    model_expect(exp_v);
    check($sformatf("cycle %0d pins", cyc), 32'(actual_vec()), 32'(exp_v));
  endtask

  task automatic reset_mid();
    #3 reset = 1'b1;
    #1;
    check("async reset pins", 32'(actual_vec()),
          32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0}));
    @(posedge clock);
    cyc++;
    #1 reset = 1'b0;
    m_v = 1'b0; p_v = 1'b0; exp_rdata = 8'h00;
  endtask

  typedef struct {
    int done_at; int done2_at; int done_cnt; int busy_cyc;
    int addr_cyc; logic [7:0] first_addr;
    int wr_cyc; int rd_cyc; int we_cnt;
  } meas_t;

  logic [7:0] wb_seen [16];
  logic [7:0] rd_seen [16];
  int wb_n;

  task automatic run_window(input bit st0, input logic [2:0] c, input int c2_off,
                            input logic [2:0] c2, input int len, output meas_t m);
    bit prev_wd, seen_addr;
    m.done_at = -1; m.done2_at = -1; m.done_cnt = 0; m.busy_cyc = 0;
    m.addr_cyc = 0; m.first_addr = 8'h00; m.wr_cyc = 0; m.rd_cyc = 0; m.we_cnt = 0;
    prev_wd = 1'b0; seen_addr = 1'b0; wb_n = 0;
    for (int i = 0; i < len; i++) begin
      if (i == 0) step(st0, c);
      else if (i == c2_off) step(1'b1, c2);
      else step(1'b0, 3'd0);
      if (done) begin
        if (m.done_cnt == 0) m.done_at = i; else m.done2_at = i;
        m.done_cnt++;
      end
      if (busy) m.busy_cyc++;
      if (!ad_n) begin
        m.addr_cyc++;
        if (!seen_addr) begin seen_addr = 1'b1; m.first_addr = ad_out; end
      end
      if (!wr_n && ad_n) begin
        m.wr_cyc++;
        if (!prev_wd && wb_n < 16) begin wb_seen[wb_n] = ad_out; wb_n++; end
      end
      prev_wd = !wr_n && ad_n;
      if (!rd_n) m.rd_cyc++;
      if (rd_we) begin
        if (m.we_cnt < 16) rd_seen[m.we_cnt] = rdata;
        m.we_cnt++;
      end
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [2:0] c;
    int done_at; int busy_cyc; int addr_cyc; logic [7:0] first_addr; int wr_cyc; int rd_cyc;
  } vec_t;

  vec_t  tab [8];
  meas_t m;

  initial begin
    tab[0] = '{3'd0,  -1,   0,  0, 8'h00,  0,  0};
    tab[1] = '{3'd3,  37,  37, 12, 8'h21, 12,  0};
    tab[2] = '{3'd2, 109, 109, 36, 8'h21,  0, 36};
    tab[3] = '{3'd1,  25,  25,  8, 8'h00,  8,  0};
    tab[4] = '{3'd4,  37,  37, 12, 8'h24, 12,  0};
    tab[5] = '{3'd5,  37,  37, 12, 8'h41, 12,  0};
    tab[6] = '{3'd6,  -1,   0,  0, 8'h00,  0,  0};
    tab[7] = '{3'd7,  -1,   0,  0, 8'h00,  0,  0};

    for (int i = 0; i < 16; i++) wtab[i] = 8'hA0 + 8'(i);
    wtab[0] = 8'h12; wtab[1] = 8'h34; wtab[2] = 8'h56;

    reset = 1'b1; start = 1'b0; cmd = 3'd0;
    #1;
    check("power-on reset pins", 32'(actual_vec()),
          32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0}));
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // Every command code, one burst each.
    for (int i = 0; i < 8; i++) begin
      run_window(1'b1, tab[i].c, -1, 3'd0, 115, m);
      check($sformatf("cmd%0d done cycle", tab[i].c), m.done_at, tab[i].done_at);
      check($sformatf("cmd%0d busy cycles", tab[i].c), m.busy_cyc, tab[i].busy_cyc);
      check($sformatf("cmd%0d addr cycles", tab[i].c), m.addr_cyc, tab[i].addr_cyc);
      check($sformatf("cmd%0d first addr", tab[i].c), 32'(m.first_addr), 32'(tab[i].first_addr));
      check($sformatf("cmd%0d wr data cycles", tab[i].c), m.wr_cyc, tab[i].wr_cyc);
      check($sformatf("cmd%0d rd data cycles", tab[i].c), m.rd_cyc, tab[i].rd_cyc);
      if (tab[i].c == 3'd3) begin
        check("wr_hora byte count", wb_n, 3);
        check("wr_hora byte0", 32'(wb_seen[0]), 32'h12);
        check("wr_hora byte1", 32'(wb_seen[1]), 32'h34);
        check("wr_hora byte2", 32'(wb_seen[2]), 32'h56);
      end
      if (tab[i].c == 3'd2) begin
        check("read rd_we pulses", m.we_cnt, 9);
        for (int j = 0; j < 9; j++)
          check($sformatf("read rdata %0d", j), 32'(rd_seen[j]), 32'h50 + j);
      end
    end

    // INIT interrupted in the second byte's data phase.
    step(1'b1, 3'd1);
    repeat (20) step(1'b0, 3'd0);
    check("init byte1 data phase wr_n", 32'(wr_n), 32'd0);
    reset_mid();
    run_window(1'b0, 3'd0, -1, 3'd0, 30, m);
    check("no done after reset", m.done_cnt, 0);
    run_window(1'b1, 3'd1, -1, 3'd0, 40, m);
    check("init after reset done cycle", m.done_at, 25);

    // Second start while busy.
    run_window(1'b1, 3'd3, 5, 3'd4, 90, m);
    check("overlap first done", m.done_at, 37);
`ifdef RTC_CMD_QUEUE_EN
    check("overlap done count", m.done_cnt, 2);
    check("overlap second done", m.done2_at, 74);
    check("overlap addr cycles", m.addr_cyc, 24);
`else
    check("overlap done count", m.done_cnt, 1);
    check("overlap addr cycles", m.addr_cyc, 12);
`endif

    // Start landing in the FIN cycle.
    run_window(1'b1, 3'd5, 38, 3'd1, 80, m);
    check("fin-start first done", m.done_at, 37);
`ifdef RTC_CMD_QUEUE_EN
    check("fin-start done count", m.done_cnt, 2);
    check("fin-start second done", m.done2_at, 62);
`else
    check("fin-start done count", m.done_cnt, 1);
`endif

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 16; i++) wtab[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 24) == 0, 3'($urandom_range(0, 7)));
    repeat (120) step(1'b0, 3'd0);
    check("idle after random run busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

- Executes the bus transactions requested by the main control FSM. It takes a one-cycle start strobe plus a 3-bit command code (same encoding as the FSM's control-mux select) and runs the matching burst of multiplexed address/data cycles on the RTC parallel bus.
- Write data comes from the data-selection mux through an index handshake. Read bytes are returned one at a time with a write strobe for the register bank.
- It sits between the main FSM and the RTC pins. It signals completion so the FSM can sequence its next step.

## Interface
Parameters:
- T_PULSE, 10: cycles each strobe (cs_n/wr_n/rd_n) stays low per phase; legal 1..255
- T_GAP, 10: cycles all strobes stay high after each phase; legal 1..255

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle command strobe
- cmd  in  3  command code, sampled with start
- wdata  in  8  write byte for the current idx; combinational from the mux
- ad_in  in  8  RTC AD bus readback
- ad_out  out  8  value driven on the AD bus
- ad_oe  out  1  AD bus output enable
- cs_n, rd_n, wr_n, ad_n  out  1 each  RTC strobes; ad_n=0 marks the address phase
- idx  out  4  byte index in the burst, 0..N-1
- rdata  out  8  last byte read
- rd_we  out  1  one-cycle strobe, rdata valid
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse

## Operation
Command table (code: direction, base address, byte count N):
- 1 INIT: write, base 0x00, N=2
- 2 READ: read, base 0x21, N=9
- 3 WR_HORA: write, base 0x21, N=3
- 4 WR_FECHA: write, base 0x24, N=3
- 5 WR_CRONO: write, base 0x41, N=3
- 0, 6, 7: ignored; no busy, no done

FSM states and flow: IDLE, A_LOW, A_GAP, D_LOW, D_GAP, FIN.
- IDLE: start with a legal cmd latches the command, sets idx=0 and busy=1, and goes to A_LOW.
- A_LOW, T_PULSE cycles: cs_n=0, wr_n=0, ad_n=0, ad_oe=1, ad_out=base+idx.
- A_GAP, T_GAP cycles: all strobes high, ad_oe=0.
- D_LOW, T_PULSE cycles: cs_n=0, ad_n=1.
  - Write: wr_n=0, ad_oe=1, ad_out=wdata. wdata is registered on entry to D_LOW and held for the whole phase.
  - Read: rd_n=0, ad_oe=0.
  - On the last D_LOW cycle, a read samples ad_in into rdata and asserts rd_we in the next cycle.
- D_GAP, T_GAP cycles: all strobes high. Then:
  - if idx==N-1, go to FIN;
  - otherwise idx increments and the FSM returns to A_LOW.
- FIN: done=1 for one cycle, busy=0, idx returns to 0, next state IDLE.

Other rules:
- ad_out is 0 whenever ad_oe=0.
- Address arithmetic is 8-bit (base+idx); it cannot overflow for the table above.
- The phase counter is 8 bits. It loads T_PULSE-1 or T_GAP-1 on phase entry and moves to the next phase on 0.

## Timing
Reset values:
- cs_n=rd_n=wr_n=ad_n=1
- ad_oe=0, ad_out=0
- idx=0, rdata=0, rd_we=0
- busy=0, done=0
- state IDLE

Latency and timing rules:
- Outputs are registered. A_LOW strobes appear on the edge after start is sampled.
- Each byte takes 2·(T_PULSE+T_GAP) cycles.
- done is high in cycle N·2·(T_PULSE+T_GAP)+1 after the start edge.
- wdata must be stable from the idx change until D_LOW entry, which is at least T_PULSE+T_GAP cycles.
- start while busy (macro off): ignored.
- start in the same cycle as done/FIN: ignored (macro off). With the macro on, it is captured per Configuration.
- Asynchronous reset mid-burst: all strobes go inactive immediately and no done is issued.

## Configuration
- RTC_CMD_QUEUE_EN defined:
  - A one-deep pending register captures the first legal start while busy (including during FIN).
  - After FIN, the FSM goes straight to A_LOW with the pending command. The start-to-done count for the pending command runs from the FIN cycle.
  - Further starts while the pending register is full are dropped.
- Undefined: no pending register; starts while busy are discarded.

## Test plan
Bench uses T_PULSE=4, T_GAP=2.
- Reset check: assert reset asynchronously mid-cycle -> all outputs at reset values before the next edge; start with cmd=0 -> no busy, no done.
- WR_HORA with wdata=0x12,0x34,0x56 keyed by idx:
  - addresses 0x21/0x22/0x23 driven with ad_n=0 for 4 cycles each;
  - data bytes driven with wr_n=0;
  - done exactly 37 cycles after the start edge (3·12+1).
- READ with ad_in = 0x50+idx during each D_LOW:
  - 9 rd_we pulses with rdata 0x50..0x58;
  - ad_oe=0 throughout data phases;
  - done at cycle 109.
- INIT interrupted by reset during the second byte's D_LOW -> strobes high immediately, no done; a new INIT then completes normally at cycle 25.
- start cmd=3 then start cmd=4 while busy:
  - macro off: second command ignored, single done;
  - macro on: WR_FECHA runs right after FIN with addresses 0x24..0x26, and two done pulses occur.
- start asserted in the FIN cycle -> macro off: ignored; macro on: executed.
